hex_monitor_display: RTL and testbench

Parametrised multi-channel hex monitor for board-level debug tops. It selects one of `CHANNELS` data words with synchronised switch inputs and captures it live or frozen. Words wider than the display are shown one digit-window ("page") at a time, with manual or automatic paging. Outputs are registered, active-low seven-segment patterns plus a change-activity flag. It replaces per-digit ad-hoc decoder instances and switch-indexed muxing in board tops.

---
 rtl/hex_monitor_display.sv | 183 ++++++++++++++++++
 tb/tb_hex_monitor_display.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_monitor_display.sv
// Multi-channel hex monitor: synchronised channel select, live/frozen snapshot,
// paged seven-segment rendering (active-low) and a stretched change-activity flag.
module hex_monitor_display #(
  parameter  int CHANNELS    = 9,
  parameter  int DATA_W      = 32,
  parameter  int DIGITS      = 6,
  parameter  int PAGE_CYCLES = 25_000_000,
  parameter  int HOLD_CYCLES = 12_500_000,
  localparam int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int PAGES       = (DATA_W + 4 * DIGITS - 1) / (4 * DIGITS),
  localparam int PAGE_W      = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       freeze,
  input  logic                       auto_page,
  input  logic                       page_step,
  output logic [8*DIGITS-1:0]        seg_n,
  output logic [PAGE_W-1:0]          page_idx,
  output logic                       sel_valid,
  output logic                       change
);

  localparam int PAD_W   = PAGES * DIGITS * 4;
  localparam int DWELL_W = $clog2(PAGE_CYCLES);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  function automatic logic [PAGE_W-1:0] page_inc(input logic [PAGE_W-1:0] p);
    page_inc = (p == PAGE_W'(PAGES - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [SEL_W-1:0]    r_sel_m, r_sel_s, r_sel_d;
  logic                r_frz_m, r_frz_s, r_frz_d;
  logic                r_auto_m, r_auto_s;
  logic                r_step_m, r_step_s, r_step_d, r_step_p;
  logic [DATA_W-1:0]   r_snap_p0;
  logic [HOLD_W-1:0]   r_hold;
  logic [DWELL_W-1:0]  r_dwell;
  logic [PAGE_W-1:0]   r_page;
  logic                r_sel_valid;
  logic                r_change;
  logic [8*DIGITS-1:0] r_seg_p1;

  logic                w_sel_chg;
  logic                w_sel_ok;
  logic                w_load;
  logic [DATA_W-1:0]   w_chan;
  logic [PAD_W-1:0]    w_pad;
  logic [8*DIGITS-1:0] w_seg_nx;
  logic [6:0]          w_code;
  logic                w_dp;
  int                  w_nib;

  assign w_sel_chg = (r_sel_s != r_sel_d);
  assign w_sel_ok  = (32'(r_sel_s) < 32'(CHANNELS));
  assign w_load    = !r_frz_s || w_sel_chg;
  assign w_pad     = PAD_W'(r_snap_p0);

  always_comb begin
    w_chan = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (r_sel_s == SEL_W'(c)) w_chan = data_in[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_m  <= '0;
      r_sel_s  <= '0;
      r_sel_d  <= '0;
      r_frz_m  <= 1'b0;
      r_frz_s  <= 1'b0;
      r_frz_d  <= 1'b0;
      r_auto_m <= 1'b0;
      r_auto_s <= 1'b0;
      r_step_m <= 1'b0;
      r_step_s <= 1'b0;
      r_step_d <= 1'b0;
      r_step_p <= 1'b0;
    end else begin
      r_sel_m  <= sel;
      r_sel_s  <= r_sel_m;
      r_sel_d  <= r_sel_s;
      r_frz_m  <= freeze;
      r_frz_s  <= r_frz_m;
      r_frz_d  <= r_frz_s;
      r_auto_m <= auto_page;
      r_auto_s <= r_auto_m;
      r_step_m <= page_step;
      r_step_s <= r_step_m;
      r_step_d <= r_step_s;
      r_step_p <= r_step_s & ~r_step_d;
    end
  end

  // Stage p0: snapshot capture, change-hold timer and page/dwell state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_p0   <= '0;
      r_hold      <= '0;
      r_change    <= 1'b0;
      r_sel_valid <= 1'b0;
      r_dwell     <= '0;
      r_page      <= '0;
    end else begin
      if (w_load) r_snap_p0 <= w_chan;
      if (w_load && !w_sel_chg && (w_chan != r_snap_p0)) r_hold <= HOLD_W'(HOLD_CYCLES);
      else if (r_hold != '0)                              r_hold <= r_hold - 1'b1;
      r_change    <= (r_hold != '0);
      r_sel_valid <= w_sel_ok;
      if (w_sel_chg) begin
        r_page  <= '0;
        r_dwell <= '0;
      end else if (r_step_p) begin
        r_page  <= page_inc(r_page);
        r_dwell <= '0;
      end else if (r_auto_s) begin
        if (r_dwell == DWELL_W'(PAGE_CYCLES - 1)) begin
          r_page  <= page_inc(r_page);
          r_dwell <= '0;
        end else begin
          r_dwell <= r_dwell + 1'b1;
        end
      end else begin
        r_dwell <= '0;
      end
    end
  end

  always_comb begin
    w_seg_nx = '1;
    w_code   = SEG_BLANK;
    w_dp     = 1'b1;
    w_nib    = 0;
    for (int d = 0; d < DIGITS; d++) begin
      w_nib = int'(r_page) * DIGITS + d;
      if (!r_sel_valid)           w_code = SEG_DASH;
      else if (w_nib * 4 >= DATA_W) w_code = SEG_BLANK;
      else                        w_code = hex7(w_pad[w_nib*4 +: 4]);
      w_dp = 1'b1;
      if (d == 0 && r_frz_d)                w_dp = 1'b0;
      if (d == DIGITS - 1 && r_page != '0)  w_dp = 1'b0;
      w_seg_nx[8*d +: 8] = {w_dp, w_code};
    end
  end

  // Stage p1: registered segment drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_seg_p1 <= '1;
    else        r_seg_p1 <= w_seg_nx;
  end

  assign seg_n     = r_seg_p1;
  assign page_idx  = r_page;
  assign sel_valid = r_sel_valid;
  assign change    = r_change;

endmodule

// File: tb/tb_hex_monitor_display.sv
// Bench for hex_monitor_display: vector table, hand-timed corner sequences and
// randomized live capture against a rule-level display model.
module tb_hex_monitor_display;
  localparam int CH = 9;
  localparam int DW = 32;
  localparam int DG = 6;
  localparam int PC = 8;
  localparam int HC = 5;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH*DW-1:0]  data_in;
  logic [3:0]        sel;
  logic              freeze, auto_page, page_step;
  logic [8*DG-1:0]   seg_n;
  logic [0:0]        page_idx;
  logic              sel_valid, change;

  hex_monitor_display #(
    .CHANNELS(CH), .DATA_W(DW), .DIGITS(DG), .PAGE_CYCLES(PC), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sel(sel), .freeze(freeze),
    .auto_page(auto_page), .page_step(page_step), .seg_n(seg_n),
    .page_idx(page_idx), .sel_valid(sel_valid), .change(change)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          sel;
    logic [31:0] val;
    logic [47:0] exp_seg;
    logic        exp_vld;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [31:0] v);
    if (c < CH) data_in[c*DW +: DW] = v;
  endtask

  task automatic pulse_step();
    page_step = 1'b1;
    tick(2);
    page_step = 1'b0;
    tick(2);
  endtask

  task automatic wait_toggle(output int cycles);
    logic p;
    p = page_idx;
    cycles = 0;
    while (cycles < 40) begin
      tick(1);
      cycles++;
      if (page_idx != p) break;
    end
  endtask

  // Display as the rules describe it: nibble (page*DIGITS+d), blanks past the word, dashes when invalid.
  function automatic logic [47:0] exp_seg(input logic [31:0] v, input int page,
                                          input bit valid, input bit frz);
    logic [47:0] r;
    logic [6:0]  code;
    logic        dp;
    int          n;
    r = '1;
    for (int d = 0; d < DG; d++) begin
      n = page * DG + d;
      if (!valid)     code = 7'b0111111;
      else if (n >= 8) code = 7'b1111111;
      else            code = HEX[v[n*4 +: 4]];
      dp = 1'b1;
      if (d == 0 && frz)        dp = 1'b0;
      if (d == DG-1 && page != 0) dp = 1'b0;
      r[8*d +: 8] = {dp, code};
    end
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c;
    int          last_diff;
    logic [31:0] snapm, v;
    logic        exp_c;

    tbl[0] = '{1,  32'hFF012345, 48'hC0F9A4B09992, 1'b1};
    tbl[1] = '{2,  32'h006789AB, 48'h82F880908883, 1'b1};
    tbl[2] = '{3,  32'h00CDEF01, 48'hC6A1868EC0F9, 1'b1};
    tbl[3] = '{9,  32'h00000000, 48'hBFBFBFBFBFBF, 1'b0};
    tbl[4] = '{6,  32'h00ABCDEF, 48'h8883C6A1868E, 1'b1};
    tbl[5] = '{12, 32'h00000000, 48'hBFBFBFBFBFBF, 1'b0};
    tbl[6] = '{7,  32'h55000000, 48'hC0C0C0C0C0C0, 1'b1};

    rst_n = 1'b0; data_in = '0; sel = 4'd0;
    freeze = 1'b0; auto_page = 1'b0; page_step = 1'b0;
    tick(3);
    chk("reset_seg", seg_n, {48{1'b1}});
    chk("reset_page", page_idx, 0);
    chk("reset_valid", sel_valid, 0);
    chk("reset_change", change, 0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < 7; i++) begin
      set_ch(tbl[i].sel, tbl[i].val);
      sel = 4'(tbl[i].sel);
      tick(6);
      chk($sformatf("tbl%0d_seg", i), seg_n, tbl[i].exp_seg);
      chk($sformatf("tbl%0d_valid", i), sel_valid, tbl[i].exp_vld);
    end

    set_ch(4, 32'h00ABCDEF);
    sel = 4'd4;
    tick(6);
    chk("basic_seg", seg_n, 48'h8883C6A1868E);
    chk("basic_valid", sel_valid, 1);
    chk("basic_change", change, 0);
    chk("basic_page", page_idx, 0);

    sel = 4'd15;
    tick(3);
    chk("inv_valid_early", sel_valid, 0);
    chk("inv_seg_not_yet", seg_n, exp_seg(32'h00ABCDEF, 0, 1, 0));
    tick(1);
    chk("inv_seg_dash", seg_n, 48'hBFBFBFBFBFBF);
    set_ch(0, 32'h00009876);
    sel = 4'd0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk($sformatf("sel0_change_%0d", i), change, 0);
    end
    chk("sel0_seg", seg_n, exp_seg(32'h00009876, 0, 1, 0));
    chk("sel0_valid", sel_valid, 1);

    set_ch(0, 32'h00001111);
    tick(1);
    chk("live_seg_lat1", seg_n, exp_seg(32'h00009876, 0, 1, 0));
    chk("live_change_lat1", change, 0);
    tick(1);
    chk("live_seg_lat2", seg_n, exp_seg(32'h00001111, 0, 1, 0));
    chk("live_change_rise", change, 1);
    tick(4);
    chk("live_change_last", change, 1);
    tick(1);
    chk("live_change_fall", change, 0);

    sel = 4'd4;
    tick(8);
    freeze = 1'b1;
    tick(3);
    chk("frz_dp_not_yet", seg_n, exp_seg(32'h00ABCDEF, 0, 1, 0));
    tick(1);
    chk("frz_dp_lit", seg_n, exp_seg(32'h00ABCDEF, 0, 1, 1));
    set_ch(4, 32'h00123456);
    tick(6);
    chk("frz_hold_seg", seg_n, exp_seg(32'h00ABCDEF, 0, 1, 1));
    chk("frz_hold_change", change, 0);
    set_ch(5, 32'h00C0FFEE);
    sel = 4'd5;
    tick(6);
    chk("frz_sel5_seg", seg_n, exp_seg(32'h00C0FFEE, 0, 1, 1));
    chk("frz_sel5_change", change, 0);
    set_ch(5, 32'h00000001);
    tick(6);
    chk("frz_sel5_held", seg_n, exp_seg(32'h00C0FFEE, 0, 1, 1));
    freeze = 1'b0;
    tick(6);
    chk("unfrz_seg", seg_n, exp_seg(32'h00000001, 0, 1, 0));
    chk("unfrz_change", change, 1);

    set_ch(5, 32'h12345678);
    tick(8);
    pulse_step();
    pulse_step();
    chk("step2_page", page_idx, 0);
    page_step = 1'b1;
    tick(3);
    chk("step3_page_lat3", page_idx, 0);
    tick(1);
    chk("step3_page_lat4", page_idx, 1);
    chk("step3_seg_lag", seg_n, exp_seg(32'h12345678, 0, 1, 0));
    tick(1);
    chk("step3_seg_page1", seg_n, 48'h7FFFFFFFF9A4);
    page_step = 1'b0;
    tick(3);
    pulse_step();
    tick(1);
    chk("step4_page", page_idx, 0);
    chk("step4_seg", seg_n, exp_seg(32'h12345678, 0, 1, 0));

    auto_page = 1'b1;
    wait_toggle(c);
    chk("auto_first_toggle", (c < 40), 1);
    wait_toggle(c);
    chk("auto_period_a", c, PC);
    wait_toggle(c);
    chk("auto_period_b", c, PC);
    if (page_idx == 1'b0) begin
      wait_toggle(c);
      chk("auto_period_c", c, PC);
    end
    tick(2);
    sel = 4'd4;
    tick(3);
    chk("auto_sel_page0", page_idx, 0);
    wait_toggle(c);
    chk("auto_restart_period", c, PC);
    auto_page = 1'b0;
    tick(4);

    set_ch(4, 32'h0000BEEF);
    tick(3);
    chk("hold_before_rst", change, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_seg", seg_n, {48{1'b1}});
    chk("midrst_page", page_idx, 0);
    chk("midrst_valid", sel_valid, 0);
    chk("midrst_change", change, 0);
    tick(2);
    rst_n = 1'b1;
    sel = 4'd2;
    tick(15);

    snapm = 32'h006789AB;
    chk("rnd_start_seg", seg_n, exp_seg(snapm, 0, 1, 0));
    chk("rnd_start_change", change, 0);
    last_diff = -100;
    for (int k = 1; k <= 200; k++) begin
      v = ($urandom_range(0, 3) == 0) ? snapm : $urandom;
      set_ch(2, v);
      tick(1);
      exp_c = (last_diff >= k - HC);
      chk($sformatf("rnd%0d_seg", k), seg_n, exp_seg(snapm, 0, 1, 0));
      chk($sformatf("rnd%0d_change", k), change, exp_c);
      if (v != snapm) last_diff = k;
      snapm = v;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
